// File: rtl/maze_tile_arbiter.sv
// maze_tile_arbiter
//   Shares the single-port maze tile RAM between the pacman mover (requester 0)
//   and the four ghost movers (requesters 1..4). A round-robin arbiter accepts
//   at most one tile lookup per cycle. A small ID pipe runs alongside each read,
//   so that the tile code returned by the RAM goes back to the mover that asked
//   for it. Returns arrive strictly in grant order.
//
// Ports
//   i_clk       system clock shared with the movers
//   i_rst       asynchronous, active-high reset
//   i_req       per-requester read request; held with its address until granted
//   i_addr      packed tile indices; requester i uses i_addr[i*ADDR_W +: ADDR_W]
//   o_gnt       one-hot single-cycle pulse: request accepted
//   o_rvalid    one-hot single-cycle pulse: o_rdata holds that requester's tile code
//   o_rdata     shared return data, meaningful only with o_rvalid
//   o_mem_addr  maze RAM address
//   o_mem_rd    maze RAM read strobe
//   i_mem_q     maze RAM read data, valid RD_LAT cycles after o_mem_rd
//   o_busy      a grant is being issued or a read is still in flight

module maze_tile_arbiter #(
    parameter int N_REQ  = 5,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*ADDR_W-1:0]   i_addr,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [N_REQ-1:0]          o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic                      o_mem_rd,
    input  logic [DATA_W-1:0]         i_mem_q,
    output logic                      o_busy
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Arbitration state
    logic [N_REQ-1:0]  r_gnt;
    logic [ID_W-1:0]   r_gntId;
    logic              r_memRd;
    logic [ADDR_W-1:0] r_memAddr;
    logic [ID_W-1:0]   r_ptr;

    // Return path state
    logic              r_pipeValid [RD_LAT];
    logic [ID_W-1:0]   r_pipeId    [RD_LAT];
    logic [N_REQ-1:0]  r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    // Arbitration combinational signals
    logic [N_REQ-1:0]  w_cand;
    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic [ADDR_W-1:0] w_winnerAddr;
    logic [ID_W-1:0]   w_nextPtr;
    logic [N_REQ-1:0]  w_gntNext;
    logic [N_REQ-1:0]  w_retOneHot;
    logic              w_pipeAny;

    // A requester whose grant is showing this cycle is masked out, so a held
    // req only competes again on the following cycle.
    assign w_cand = i_req & ~r_gnt;

    // Round-robin search: scan candidates starting at the pointer, wrapping
    // modulo N_REQ, and take the first one found.
    always_comb begin
        int idx;
        idx          = 0;
        w_found      = 1'b0;
        w_winner     = '0;
        w_winnerAddr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_found && w_cand[idx]) begin
                w_found      = 1'b1;
                w_winner     = ID_W'(idx);
                w_winnerAddr = i_addr[idx*ADDR_W +: ADDR_W];
            end
        end
    end

    // Pointer moves to the slot just after the winner, wrapping to 0.
    always_comb begin
        w_nextPtr = (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + ID_W'(1);
    end

    always_comb begin
        w_gntNext = '0;
        if (w_found) begin
            w_gntNext[w_winner] = 1'b1;
        end
    end

    // Grant, RAM strobe and pointer registers. With no candidate the RAM
    // address is left alone and the pointer keeps its place.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gnt     <= '0;
            r_gntId   <= '0;
            r_memRd   <= 1'b0;
            r_memAddr <= '0;
            r_ptr     <= '0;
        end else begin
            r_gnt   <= w_gntNext;
            r_memRd <= w_found;
            if (w_found) begin
                r_gntId   <= w_winner;
                r_memAddr <= w_winnerAddr;
                r_ptr     <= w_nextPtr;
            end
        end
    end

    // ID pipe: stage 0 captures the read issued this cycle. The last stage
    // lines up with the cycle in which the RAM presents its data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_pipeValid[k] <= 1'b0;
                r_pipeId[k]    <= '0;
            end
        end else begin
            r_pipeValid[0] <= r_memRd;
            r_pipeId[0]    <= r_gntId;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pipeValid[k] <= r_pipeValid[k-1];
                r_pipeId[k]    <= r_pipeId[k-1];
            end
        end
    end

    always_comb begin
        w_retOneHot = '0;
        if (r_pipeValid[RD_LAT-1]) begin
            w_retOneHot[r_pipeId[RD_LAT-1]] = 1'b1;
        end
    end

    // Register the returned tile code together with its owner's strobe.
    // rdata keeps its last value between returns.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_retOneHot;
            if (r_pipeValid[RD_LAT-1]) begin
                r_rdata <= i_mem_q;
            end
        end
    end

    always_comb begin
        w_pipeAny = 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
            w_pipeAny = w_pipeAny | r_pipeValid[k];
        end
    end

    assign o_gnt      = r_gnt;
    assign o_mem_rd   = r_memRd;
    assign o_mem_addr = r_memAddr;
    assign o_rvalid   = r_rvalid;
    assign o_rdata    = r_rdata;
    assign o_busy     = (|r_gnt) | w_pipeAny;

endmodule

// File: tb/tb_maze_tile_arbiter.sv
// Bench for maze_tile_arbiter: dut (RD_LAT=1) and dutSlow (RD_LAT=3), each
// with its own behavioural maze RAM. Outputs are sampled at the falling edge.
module tb_maze_tile_arbiter;

    localparam int N  = 5;
    localparam int AW = 10;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;

    logic [N-1:0]    reqA, gntA, rvalidA;
    logic [N*AW-1:0] addrA;
    logic [DW-1:0]   rdataA, memQA;
    logic [AW-1:0]   memAddrA;
    logic            memRdA, busyA;

    logic [N-1:0]    reqB, gntB, rvalidB;
    logic [N*AW-1:0] addrB;
    logic [DW-1:0]   rdataB, memQB;
    logic [AW-1:0]   memAddrB;
    logic            memRdB, busyB;

    logic [DW-1:0] ramA [1024];
    logic [DW-1:0] ramB [1024];
    logic [DW-1:0] qPipeA;
    logic [DW-1:0] qPipeB [3];

    int nCompared   = 0;
    int nMismatched = 0;

    // Clock generation, 10 ns period
    always #5 clk = ~clk;

    maze_tile_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(reqA), .i_addr(addrA),
        .o_gnt(gntA), .o_rvalid(rvalidA), .o_rdata(rdataA),
        .o_mem_addr(memAddrA), .o_mem_rd(memRdA), .i_mem_q(memQA), .o_busy(busyA)
    );

    maze_tile_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dutSlow (
        .i_clk(clk), .i_rst(rst), .i_req(reqB), .i_addr(addrB),
        .o_gnt(gntB), .o_rvalid(rvalidB), .o_rdata(rdataB),
        .o_mem_addr(memAddrB), .o_mem_rd(memRdB), .i_mem_q(memQB), .o_busy(busyB)
    );

    // Maze RAM models: data appears RD_LAT cycles after the address is sampled
    always @(posedge clk) begin
        qPipeA <= ramA[memAddrA];
    end
    assign memQA = qPipeA;

    always @(posedge clk) begin
        qPipeB[0] <= ramB[memAddrB];
        qPipeB[1] <= qPipeB[0];
        qPipeB[2] <= qPipeB[1];
    end
    assign memQB = qPipeB[2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] req);
        reqA = req;
    endtask

    task automatic setAddrA(input int idx, input logic [AW-1:0] a);
        addrA[idx*AW +: AW] = a;
    endtask

    int seq [7] = '{0, 1, 2, 3, 4, 0, 1};

    initial begin
        rst   = 1'b1;
        reqA  = '0;
        addrA = '0;
        reqB  = '0;
        addrB = '0;
        for (int i = 0; i < 1024; i++) begin
            ramA[i] = 4'h0;
            ramB[i] = 4'h0;
        end
        ramA[37] = 4'hA;
        for (int i = 0; i < N; i++) begin
            ramA[100 + i] = DW'(i + 1);
        end
        ramB[300] = 4'h5;
        ramB[301] = 4'h7;

        // Reset values
        @(negedge clk);
        checkOutput("rst_gnt",    gntA,     0);
        checkOutput("rst_rvalid", rvalidA,  0);
        checkOutput("rst_memrd",  memRdA,   0);
        checkOutput("rst_memaddr", memAddrA, 0);
        checkOutput("rst_busy",   busyA,    0);
        checkOutput("rst_rdata",  rdataA,   0);
        rst = 1'b0;

        // Single read from requester 2
        setAddrA(2, 10'd37);
        applyStimulus(5'b00100);
        @(negedge clk);
        checkOutput("t2_gnt",     gntA,     5'b00100);
        checkOutput("t2_memaddr", memAddrA, 37);
        checkOutput("t2_memrd",   memRdA,   1);
        checkOutput("t2_busy1",   busyA,    1);
        applyStimulus(5'b00000);
        @(negedge clk);
        checkOutput("t2_gnt_off", gntA,     0);
        checkOutput("t2_busy2",   busyA,    1);
        checkOutput("t2_rv_early", rvalidA, 0);
        @(negedge clk);
        checkOutput("t2_rvalid",  rvalidA,  5'b00100);
        checkOutput("t2_rdata",   rdataA,   4'hA);
        checkOutput("t2_busy3",   busyA,    0);

        // Mid-cycle asynchronous reset clears outputs immediately
        setAddrA(1, 10'd55);
        applyStimulus(5'b00010);
        @(negedge clk);
        checkOutput("t1_pre_gnt", gntA, 5'b00010);
        applyStimulus(5'b00000);
        #2 rst = 1'b1;
        #1;
        checkOutput("t1_gnt",     gntA,     0);
        checkOutput("t1_memrd",   memRdA,   0);
        checkOutput("t1_memaddr", memAddrA, 0);
        checkOutput("t1_busy",    busyA,    0);
        @(negedge clk);
        rst = 1'b0;

        // All requesters held: rotation from pointer 0
        for (int i = 0; i < N; i++) begin
            setAddrA(i, AW'(100 + i));
        end
        applyStimulus(5'b11111);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 7) begin
                checkOutput($sformatf("t3_gnt%0d", k),     gntA,     32'd1 << seq[k-1]);
                checkOutput($sformatf("t3_memrd%0d", k),   memRdA,   1);
                checkOutput($sformatf("t3_memaddr%0d", k), memAddrA, 100 + seq[k-1]);
            end
            if (k == 7) applyStimulus(5'b00000);
            if (k == 8) checkOutput("t3_gnt_idle", gntA, 0);
            if (k >= 3) begin
                checkOutput($sformatf("t3_rvalid%0d", k), rvalidA, 32'd1 << seq[k-3]);
                checkOutput($sformatf("t3_rdata%0d", k),  rdataA,  seq[k-3] + 1);
            end
        end

        // Pointer wrap: pointer is now 2
        setAddrA(4, 10'd200);
        setAddrA(0, 10'd201);
        setAddrA(3, 10'd202);
        applyStimulus(5'b10000);
        @(negedge clk);
        checkOutput("t4_gnt4", gntA, 5'b10000);
        applyStimulus(5'b01001);
        @(negedge clk);
        checkOutput("t4_gnt0",     gntA,     5'b00001);
        checkOutput("t4_memaddr0", memAddrA, 201);
        applyStimulus(5'b01000);
        @(negedge clk);
        checkOutput("t4_gnt3",     gntA,     5'b01000);
        checkOutput("t4_memaddr3", memAddrA, 202);
        applyStimulus(5'b00000);

        // Held request is not re-granted while its grant is showing; pointer is 4
        applyStimulus(5'b00001);
        @(negedge clk);
        checkOutput("rg_gnt1", gntA, 5'b00001);
        @(negedge clk);
        checkOutput("rg_gnt2",    gntA,     0);
        checkOutput("rg_memrd2",  memRdA,   0);
        checkOutput("rg_addrhold", memAddrA, 201);
        @(negedge clk);
        checkOutput("rg_gnt3", gntA, 5'b00001);
        applyStimulus(5'b00000);
        repeat (3) @(negedge clk);

        // Reset with two reads in flight; pointer is 1
        applyStimulus(5'b00011);
        @(negedge clk);
        checkOutput("t5_gnt1", gntA, 5'b00010);
        applyStimulus(5'b00001);
        @(negedge clk);
        checkOutput("t5_gnt0", gntA, 5'b00001);
        checkOutput("t5_busy_pre", busyA, 1);
        applyStimulus(5'b00000);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_busy_rst", busyA, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t5_rvalid%0d", k), rvalidA, 0);
            checkOutput($sformatf("t5_busy%0d", k),   busyA,   0);
        end

        // RD_LAT=3: requesters 1 and 2 back to back
        addrB[1*AW +: AW] = 10'd300;
        addrB[2*AW +: AW] = 10'd301;
        reqB = 5'b00110;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput("t6_gnt1", gntB, 5'b00010);
                reqB = 5'b00100;
            end
            if (k == 2) begin
                checkOutput("t6_gnt2", gntB, 5'b00100);
                reqB = 5'b00000;
            end
            if (k == 5) begin
                checkOutput("t6_rvalid5", rvalidB, 5'b00010);
                checkOutput("t6_rdata5",  rdataB,  4'h5);
            end else if (k == 6) begin
                checkOutput("t6_rvalid6", rvalidB, 5'b00100);
                checkOutput("t6_rdata6",  rdataB,  4'h7);
            end else begin
                checkOutput($sformatf("t6_rvalid%0d", k), rvalidB, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
